// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013);
  localparam logic [INSTR_W-1:0] PC_STEP   = INSTR_W'(4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Fetch address select: redirect / advance / replay mux, +4 adder and bounds comparator.
module fetch_next_pc
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  input  logic               adv,
  input  logic [INSTR_W-1:0] pc,
  input  logic [INSTR_W-1:0] req_pc,
  output logic [INSTR_W-1:0] pcsel_c,
  output logic [INSTR_W-1:0] pc_next_c,
  output logic [INSTR_W-1:0] fault_pc_c,
  output logic               fault_c
);

  logic misalign_c;

  always_comb begin
    pcsel_c = req_pc;
    if (redirect) begin
      pcsel_c = {redirect_pc[INSTR_W-1:2], 2'b00};
    end else if (adv) begin
      pcsel_c = pc;
    end
    pc_next_c  = pcsel_c + PC_STEP;
    misalign_c = redirect && (redirect_pc[1:0] != 2'b00);
    fault_c    = misalign_c || (pcsel_c[INSTR_W-1:2] >= (INSTR_W-2)'(MEM_WORDS));
    // Misaligned targets are reported with their raw low bits for debug.
    fault_pc_c = misalign_c ? redirect_pc : pcsel_c;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC/fetch stage feeding a 1-cycle-latency instruction memory and a valid/ready decode port.
// Optional FETCH_BOUNDS_CHECK_EN adds address-range/alignment faulting.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic [INSTR_W-1:0]  MemAddress,
  input  logic [INSTR_W-1:0]  MemReadData,
  input  logic                InstrReady,
  output logic                InstrValid,
  output logic [INSTR_W-1:0]  Instr,
  output logic [INSTR_W-1:0]  InstrPC,
  input  logic                Redirect,
  input  logic [INSTR_W-1:0]  RedirectPC,
  output logic                InstrFault
);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_CHECK = 1'b1;
`else
  localparam bit BOUNDS_CHECK = 1'b0;
`endif

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] req_pc_q, req_pc_d;

  logic               adv_c;
  logic [INSTR_W-1:0] pcsel_c, pc_next_c, fault_pc_c;
  logic               fault_c;

  assign adv_c = (state_q == BOOT) ||
                 ((state_q == RUN) && InstrReady && !Redirect);

  fetch_next_pc #(
    .MEM_WORDS (MEM_WORDS)
  ) u_next_pc (
    .redirect    (Redirect),
    .redirect_pc (RedirectPC),
    .adv         (adv_c),
    .pc          (pc_q),
    .req_pc      (req_pc_q),
    .pcsel_c     (pcsel_c),
    .pc_next_c   (pc_next_c),
    .fault_pc_c  (fault_pc_c),
    .fault_c     (fault_c)
  );

  // Next-state: any redirect or advance issues pcsel; a stall holds everything.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (Redirect || adv_c) begin
      if (BOUNDS_CHECK && fault_c) begin
        state_d  = FAULT;
        req_pc_d = fault_pc_c;
        pc_d     = pc_next_c;
      end else begin
        state_d  = RUN;
        req_pc_d = pcsel_c;
        pc_d     = pc_next_c;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Memory address and decode-side outputs; the Redirect paths here are intentionally combinational.
  always_comb begin
    MemAddress = {2'b00, pcsel_c[INSTR_W-1:2]};
    if (BOUNDS_CHECK && (state_q == FAULT) && !Redirect) begin
      MemAddress = '0;
    end
    InstrValid = (state_q == RUN) && !Redirect;
    Instr      = InstrValid ? MemReadData : NOP_INSTR;
    InstrPC    = req_pc_q;
    InstrFault = BOUNDS_CHECK && (state_q == FAULT);
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit with a 64-word registered-read memory model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        rdy;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redir;
  logic [31:0] redir_pc;
  logic        fault;

  logic [31:0] mem [64];

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (64)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .MemAddress  (mem_addr),
    .MemReadData (mem_rdata),
    .InstrReady  (rdy),
    .InstrValid  (valid),
    .Instr       (instr),
    .InstrPC     (instr_pc),
    .Redirect    (redir),
    .RedirectPC  (redir_pc),
    .InstrFault  (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr[5:0]];

  function automatic logic [31:0] word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the falling edge, then let combinational outputs settle.
  task automatic cyc(input logic r, input logic rd, input logic rdr, input logic [31:0] rpc);
    @(negedge clk);
    rst      = r;
    rdy      = rd;
    redir    = rdr;
    redir_pc = rpc;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = word(i);
    rst = 1'b1; rdy = 1'b0; redir = 1'b0; redir_pc = '0;
    mem_rdata = '0;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);

    // Boot cycle then streaming
    cyc(0, 1, 0, 0);
    chk("boot_valid", 32'(valid), 32'd0);
    chk("boot_addr", mem_addr, 32'd0);
    cyc(0, 1, 0, 0);
    chk("s0_valid", 32'(valid), 32'd1);
    chk("s0_pc", instr_pc, 32'h0);
    chk("s0_instr", instr, word(0));
    chk("s0_addr", mem_addr, 32'd1);
    cyc(0, 1, 0, 0);
    chk("s1_pc", instr_pc, 32'h4);
    chk("s1_instr", instr, word(1));
    chk("s1_addr", mem_addr, 32'd2);

    // Stall three cycles at 0x8
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0);
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_pc", instr_pc, 32'h8);
      chk("stall_instr", instr, word(2));
      chk("stall_addr", mem_addr, 32'd2);
    end
    cyc(0, 1, 0, 0);
    chk("rel_pc", instr_pc, 32'h8);
    chk("rel_addr", mem_addr, 32'd3);
    cyc(0, 1, 0, 0);
    chk("post_pc", instr_pc, 32'hC);
    chk("post_instr", instr, word(3));

    // Redirect during a stall at 0x10
    cyc(0, 0, 0, 0);
    chk("st2_pc", instr_pc, 32'h10);
    cyc(0, 0, 1, 32'h20);
    chk("rd_valid", 32'(valid), 32'd0);
    chk("rd_instr", instr, NOP);
    chk("rd_addr", mem_addr, 32'd8);
    cyc(0, 1, 0, 0);
    chk("tgt_valid", 32'(valid), 32'd1);
    chk("tgt_pc", instr_pc, 32'h20);
    chk("tgt_instr", instr, word(8));
    chk("tgt_addr", mem_addr, 32'd9);
    cyc(0, 1, 0, 0);
    chk("tgt1_pc", instr_pc, 32'h24);
    chk("tgt1_instr", instr, word(9));
    cyc(0, 1, 0, 0);
    chk("tgt2_pc", instr_pc, 32'h28);

    // Reset together with a redirect: reset wins
    cyc(1, 1, 1, 32'h40);
    cyc(0, 1, 0, 0);
    chk("rr_valid", 32'(valid), 32'd0);
    chk("rr_instr", instr, NOP);
    chk("rr_pc", instr_pc, 32'h0);
    chk("rr_addr", mem_addr, 32'd0);
    cyc(0, 1, 0, 0);
    chk("rr1_pc", instr_pc, 32'h0);
    chk("rr1_instr", instr, word(0));

    // Redirect drops low PC bits when unchecked
`ifndef FETCH_BOUNDS_CHECK_EN
    cyc(0, 1, 1, 32'h36);
    chk("ua_addr", mem_addr, 32'hD);
    cyc(0, 1, 0, 0);
    chk("ua_pc", instr_pc, 32'h34);
    chk("ua_instr", instr, word(13));

    // PC wrap at top of address space
    cyc(0, 1, 1, 32'hFFFF_FFFC);
    chk("wr_addr", mem_addr, 32'h3FFF_FFFF);
    cyc(0, 1, 0, 0);
    chk("wr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wr_instr", instr, word(63));
    chk("wr_next", mem_addr, 32'd0);
    chk("wr_fault", 32'(fault), 32'd0);
    cyc(0, 1, 0, 0);
    chk("wr1_pc", instr_pc, 32'h0);
    chk("wr1_instr", instr, word(0));
`else
    cyc(0, 1, 1, 32'h100);
    chk("oob_addr", mem_addr, 32'h40);
    cyc(0, 1, 0, 0);
    chk("oob_fault", 32'(fault), 32'd1);
    chk("oob_valid", 32'(valid), 32'd0);
    chk("oob_pc", instr_pc, 32'h100);
    chk("oob_maddr", mem_addr, 32'd0);
    cyc(0, 1, 0, 0);
    chk("oob_hold", 32'(fault), 32'd1);
    cyc(0, 1, 1, 32'h4);
    chk("clr_addr", mem_addr, 32'd1);
    cyc(0, 1, 0, 0);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_valid", 32'(valid), 32'd1);
    chk("clr_pc", instr_pc, 32'h4);
    chk("clr_instr", instr, word(1));
    cyc(0, 1, 1, 32'h6);
    cyc(0, 1, 0, 0);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_valid", 32'(valid), 32'd0);
    chk("mis_pc", instr_pc, 32'h6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
